// File: rtl/rx_result_checker.sv
// Post-run TX/RX memory comparator: sweeps both sample memories in address order and
// reports mismatch count, first mismatching address and an OR-ed bit-error mask over Avalon-MM.
module rx_result_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int RD_LATENCY = 2
) (
    input  logic                  AVALON_CLK,
    input  logic                  AVALON_RESET,
    input  logic [1:0]            AVALON_ADDRESS,
    input  logic                  AVALON_CHIPSELECT,
    input  logic                  AVALON_WRITE,
    input  logic                  AVALON_READ,
    input  logic [31:0]           AVALON_WRITEDATA,
    output logic [31:0]           AVALON_READDATA,
    output logic [ADDR_WIDTH-1:0] CHK_TX_MEMADDR,
    output logic [ADDR_WIDTH-1:0] CHK_RX_MEMADDR,
    input  logic [DATA_WIDTH-1:0] CHK_TX_RDDATA,
    input  logic [DATA_WIDTH-1:0] CHK_RX_RDDATA
);
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    // All pipeline stages except the oldest; the oldest is consumed on the edge that leaves DRAIN.
    localparam logic [RD_LATENCY-1:0] PEND_MASK = {RD_LATENCY{1'b1}} >> 1;

    state_t                                state_q, state_d;
    logic [ADDR_WIDTH-1:0]                 addr_q, addr_d;
    logic [RD_LATENCY-1:0]                 vld_pipe_q, vld_pipe_d;
    logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] addr_pipe_q, addr_pipe_d;
    logic                                  done_q, done_d;
    logic [CNT_W-1:0]                      count_q, count_d;
    logic                                  first_valid_q, first_valid_d;
    logic [ADDR_WIDTH-1:0]                 first_addr_q, first_addr_d;
    logic [DATA_WIDTH-1:0]                 err_mask_q, err_mask_d;
    logic [31:0]                           rdata_q, rdata_d;

    logic                  wr_en, start, clear, busy;
    logic [DATA_WIDTH-1:0] diff;
    logic                  unused_wdata;

    assign unused_wdata   = ^AVALON_WRITEDATA[31:2];
    assign CHK_TX_MEMADDR = addr_q;
    assign CHK_RX_MEMADDR = addr_q;
    assign AVALON_READDATA = rdata_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        done_d        = done_q;
        count_d       = count_q;
        first_valid_d = first_valid_q;
        first_addr_d  = first_addr_q;
        err_mask_d    = err_mask_q;
        rdata_d       = rdata_q;

        wr_en = AVALON_CHIPSELECT && AVALON_WRITE && (AVALON_ADDRESS == 2'd0);
        start = wr_en && AVALON_WRITEDATA[0];
        clear = wr_en && AVALON_WRITEDATA[1];
        busy  = (state_q == S_SWEEP) || (state_q == S_DRAIN);

        vld_pipe_d[0]  = (state_q == S_SWEEP);
        addr_pipe_d[0] = addr_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            addr_pipe_d[i] = addr_pipe_q[i-1];
        end

        diff = CHK_TX_RDDATA ^ CHK_RX_RDDATA;
        if (vld_pipe_q[RD_LATENCY-1]) begin
            err_mask_d = err_mask_q | diff;
            if (diff != '0) begin
                count_d = count_q + CNT_W'(1);
                if (!first_valid_q) begin
                    first_valid_d = 1'b1;
                    first_addr_d  = addr_pipe_q[RD_LATENCY-1];
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                // Start implies clear, so both paths wipe the results.
                if (start || clear) begin
                    done_d        = 1'b0;
                    count_d       = '0;
                    first_valid_d = 1'b0;
                    first_addr_d  = '0;
                    err_mask_d    = '0;
                end
                if (start) state_d = S_SWEEP;
            end
            S_SWEEP: begin
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((vld_pipe_q & PEND_MASK) == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (AVALON_CHIPSELECT && AVALON_READ) begin
            case (AVALON_ADDRESS)
                2'd0:    rdata_d = {30'b0, busy, done_q};
                2'd1:    rdata_d = 32'(count_q);
                2'd2:    rdata_d = {first_valid_q, 31'(first_addr_q)};
                default: rdata_d = 32'(err_mask_q);
            endcase
        end
    end

    always_ff @(posedge AVALON_CLK) begin
        if (AVALON_RESET) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            vld_pipe_q    <= '0;
            addr_pipe_q   <= '0;
            done_q        <= 1'b0;
            count_q       <= '0;
            first_valid_q <= 1'b0;
            first_addr_q  <= '0;
            err_mask_q    <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            vld_pipe_q    <= vld_pipe_d;
            addr_pipe_q   <= addr_pipe_d;
            done_q        <= done_d;
            count_q       <= count_d;
            first_valid_q <= first_valid_d;
            first_addr_q  <= first_addr_d;
            err_mask_q    <= err_mask_d;
            rdata_q       <= rdata_d;
        end
    end
endmodule

// File: tb/tb_rx_result_checker.sv
// Randomized scoreboard bench for rx_result_checker with a 2-cycle memory model.
module tb_rx_result_checker;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic        cs, wr, rd;
    logic [31:0] wdata, rdata;
    logic [8:0]  tx_addr, rx_addr;
    logic [31:0] tx_rd, rx_rd, tx_p1, rx_p1;

    logic [31:0] tx_mem [512];
    logic [31:0] rx_mem [512];

    int errs = 0;
    int checks = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        rd_seen = 1'b0;

    logic [31:0] exp1, exp2, exp3;

    always #5 clk = ~clk;

    rx_result_checker #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .RD_LATENCY(2)) dut (
        .AVALON_CLK(clk), .AVALON_RESET(rst), .AVALON_ADDRESS(addr),
        .AVALON_CHIPSELECT(cs), .AVALON_WRITE(wr), .AVALON_READ(rd),
        .AVALON_WRITEDATA(wdata), .AVALON_READDATA(rdata),
        .CHK_TX_MEMADDR(tx_addr), .CHK_RX_MEMADDR(rx_addr),
        .CHK_TX_RDDATA(tx_rd), .CHK_RX_RDDATA(rx_rd)
    );

    // Two-stage registered memories: address in cycle c, data during cycle c+2.
    always @(posedge clk) begin
        tx_p1 <= tx_mem[tx_addr];
        rx_p1 <= rx_mem[rx_addr];
        tx_rd <= tx_p1;
        rx_rd <= rx_p1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every accepted read returns data one edge later.
    always @(posedge clk) rd_seen <= cs && rd && !rst;
    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check(name_q.pop_front(), rdata, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cs = 0; wr = 0; rd = 0; addr = 0; wdata = 0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        cs = 1; wr = 1; addr = a; wdata = d;
        tick();
        idle_bus();
    endtask

    task automatic do_read(input logic [1:0] a, input logic [31:0] e, input string nm);
        cs = 1; rd = 1; addr = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        tick();
        idle_bus();
    endtask

    // Reference: what a full sweep should report, straight from the memory contents.
    task automatic model();
        int cnt = 0;
        bit fv = 0;
        int fa = 0;
        logic [31:0] m = 0;
        for (int a = 0; a < 512; a++) begin
            logic [31:0] d = tx_mem[a] ^ rx_mem[a];
            m |= d;
            if (d != 0) begin
                cnt++;
                if (!fv) begin fv = 1; fa = a; end
            end
        end
        exp1 = 32'(cnt);
        exp2 = (fv ? 32'h8000_0000 : 32'h0) | 32'(fa);
        exp3 = m;
    endtask

    // mode 0: equal, 1: one error at 300, 2: inverted, 3: sparse random errors
    task automatic fill(input int mode);
        for (int a = 0; a < 512; a++) begin
            tx_mem[a] = $urandom;
            rx_mem[a] = tx_mem[a];
            if (mode == 2) rx_mem[a] = ~tx_mem[a];
            if (mode == 3 && $urandom_range(15) == 0)
                rx_mem[a] = tx_mem[a] ^ (32'd1 << $urandom_range(31));
        end
        if (mode == 1) begin
            tx_mem[300] = 32'hA5A5A5A5;
            rx_mem[300] = 32'hA5A5A585;
        end
    endtask

    // Issues a start, then reads reg0 every cycle of the run; optional extra start or reset.
    task automatic run_sweep(input logic [31:0] sv, input int disturb_n, input int abort_n);
        do_write(2'd0, sv);
        for (int n = 1; n <= 515; n++) begin
            logic [31:0] ea = (n <= 512) ? 32'(n - 1) : 32'd0;
            if (n == abort_n) begin
                rst = 1;
                tick();
                check("rst_readdata", rdata, 32'd0);
                check("rst_tx_addr", 32'(tx_addr), 32'd0);
                check("rst_rx_addr", 32'(rx_addr), 32'd0);
                rst = 0;
                return;
            end
            check("tx_addr", 32'(tx_addr), ea);
            check("rx_addr", 32'(rx_addr), ea);
            cs = 1; rd = 1; addr = 0;
            if (n == disturb_n) begin wr = 1; wdata = 32'd1; end
            exp_q.push_back((n <= 514) ? 32'd2 : 32'd1);
            name_q.push_back("reg0_run");
            tick();
            idle_bus();
        end
    endtask

    task automatic check_results(input string tag);
        model();
        do_read(2'd1, exp1, {tag, "_reg1"});
        do_read(2'd2, exp2, {tag, "_reg2"});
        do_read(2'd3, exp3, {tag, "_reg3"});
        do_read(2'd0, 32'd1, {tag, "_reg0"});
    endtask

    task automatic check_zero(input string tag);
        do_read(2'd0, 32'd0, {tag, "_reg0"});
        do_read(2'd1, 32'd0, {tag, "_reg1"});
        do_read(2'd2, 32'd0, {tag, "_reg2"});
        do_read(2'd3, 32'd0, {tag, "_reg3"});
    endtask

    initial begin
        idle_bus();
        rst = 1;
        fill(0);
        repeat (3) tick();
        check("reset_readdata", rdata, 32'd0);
        check("reset_addr", 32'(tx_addr), 32'd0);
        rst = 0;
        check_zero("after_reset");

        fill(0);
        run_sweep(32'd1, 0, 0);
        check_results("equal");

        fill(1);
        run_sweep(32'd1, 0, 0);
        check_results("single");

        fill(2);
        run_sweep(32'd1, 0, 0);
        check_results("inverted");

        fill(3);
        run_sweep(32'd1, 101, 0);
        check_results("restart_ignored");

        fill(3);
        run_sweep(32'd3, 0, 0);
        check_results("start_and_clear");

        fill(2);
        run_sweep(32'd1, 0, 101);
        tick();
        check_zero("mid_reset");
        fill(3);
        run_sweep(32'd1, 0, 0);
        check_results("after_abort");

        do_write(2'd0, 32'd2);
        check_zero("cleared");

        fill(2);
        run_sweep(32'd1, 0, 0);
        fill(0);
        run_sweep(32'd1, 0, 0);
        check_results("back_to_back");

        repeat (3) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/rx_result_checker.md
# rx_result_checker

Post-run verifier for the loopback benchmark. On a start command from the Avalon-MM host, it sweeps the 512-entry TX and RX sample memories in address order and compares each TX/RX entry pair. It accumulates a mismatch count, the first mismatching address and an OR-ed bit-error mask, then reports them through Avalon registers. It is the reader-side counterpart to the control unit that fills those memories, and sits on the Avalon clock beside it.

## Interface
- DATA_WIDTH, 32: width of one memory word (1..32).
- ADDR_WIDTH, 9: memory address width; the sweep covers 2^ADDR_WIDTH entries.
- RD_LATENCY, 2: memory read latency in cycles, from address to data (>=1).

Ports:
- AVALON_CLK  in  1  sole clock.
- AVALON_RESET  in  1  synchronous, active-high reset.
- AVALON_ADDRESS  in  2  register select.
- AVALON_CHIPSELECT  in  1  qualifies read and write.
- AVALON_WRITE  in  1  write strobe.
- AVALON_READ  in  1  read strobe.
- AVALON_WRITEDATA  in  32  write data.
- AVALON_READDATA  out  32  registered read data.
- CHK_TX_MEMADDR  out  ADDR_WIDTH  TX memory read address.
- CHK_RX_MEMADDR  out  ADDR_WIDTH  RX memory read address (same value as TX).
- CHK_TX_RDDATA  in  DATA_WIDTH  TX memory read data.
- CHK_RX_RDDATA  in  DATA_WIDTH  RX memory read data.

## Operation
- Register map:
  - Reg 0, read: {30'b0, busy, done}.
  - Reg 0, write: bit0 = start; bit1 = clear.
  - Reg 1: {22'b0, mismatch_count[9:0]}.
  - Reg 2: {first_valid, 22'b0, first_addr[8:0]}.
  - Reg 3: {zero-extended err_mask}.
- A write is accepted only when CHIPSELECT and WRITE are both high.
- State machine:
  - IDLE: start -> SWEEP. Clear (with no start) zeroes done, count, first_valid, first_addr and err_mask.
  - SWEEP: issue one address per cycle, 0 through 511. After issuing 511 -> DRAIN.
  - DRAIN: wait until the valid pipeline is empty -> DONE.
  - DONE: set done=1 for one transition, then -> IDLE.
- Accepting start clears all results and done in the same edge that enters SWEEP.
- Start or clear while busy (SWEEP or DRAIN) is ignored.
- If start and clear arrive together in IDLE, start takes effect (its clear is implied).
- A valid/address shift register of length RD_LATENCY tracks each issued address through the memory read. When its output is valid, TX and RX data are compared at that edge:
  - diff = TX ^ RX.
  - err_mask |= diff.
  - If diff != 0: count++. If first_valid is 0, capture the address and set first_valid.
- Count width is 10 bits, so the maximum of 512 cannot overflow.
- Addresses wrap 511 -> 0 at the end of SWEEP; the address is held at 0 outside SWEEP.
- Reset values:
  - READDATA = 0 and all results = 0.
  - busy = 0, done = 0, state IDLE, memory addresses = 0.
  - Valid pipeline flushed.
- Reset asserted mid-sweep abandons the run. Nothing is retained, and the next start begins fresh.

## Timing
- Avalon read latency is 1: READDATA is registered from the register selected on the previous cycle.
- Reads return values as of the previous edge. With no active read, READDATA holds its value.
- A start write sampled at edge T puts address k on both memory ports during cycle T+1+k, for k = 0..511.
- Data for address k is compared at the edge ending cycle T+1+k+RD_LATENCY.
- busy reads 1 from cycle T+1 through cycle T+512+RD_LATENCY.
- done reads 1 from cycle T+513+RD_LATENCY until the next start, clear or reset.
- Total run time is 512+RD_LATENCY+1 cycles from start.
- Back-to-back runs: a start is accepted on the first cycle in which done=1 reads back.

## Test plan
- Identical TX and RX contents, RD_LATENCY=2, start -> done after 515 cycles; reg1=0, reg2=0x00000000, reg3=0; busy observed high for 514 cycles.
- Single mismatch at address 300, TX=0xA5A5A5A5 vs RX=0xA5A5A585 -> reg1=1, reg2=0x8000012C, reg3=0x00000020.
- RX = ~TX everywhere -> reg1=0x200, reg2=0x80000000, reg3=0xFFFFFFFF; the count does not wrap.
- Start written again at address 100 of a sweep -> the sweep continues unaffected and completes with the same totals as an undisturbed run.
- Reset asserted while the address is 100 -> next cycle all registers read 0, addresses are 0 and busy=0. A fresh start then completes normally.
- Run with mismatches, then write clear (0x2) -> reg0..reg3 all read 0. A second start after a completed run clears the old results before the new sweep.
